// File: rtl/axi_mem_arbiter.sv
// Two-master AXI4-Lite arbiter: M0 (read-only) and M1 (read/write) share one slave.
// One outstanding transaction; grant is registered, the granted master's channels pass through.
module axi_mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    // M0: read only
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    // M1: read and write
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    output logic [1:0]              m1_bresp,
    // Slave side
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    input  logic [1:0]              s_bresp
);

    typedef enum logic [2:0] {StIdle, StRdM0, StRdM1, StWrM1, StWresp} state_t;

    state_t state_q;
    logic   last_m1_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic m0_req, m1_rd_req, m1_wr_req, m1_req, m1_wins;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // AW without W does not count as a write request
    assign m0_req    = m0_arvalid;
    assign m1_rd_req = m1_arvalid;
    assign m1_wr_req = m1_awvalid && m1_wvalid;
    assign m1_req    = m1_rd_req || m1_wr_req;
    assign m1_wins   = (ROUND_ROBIN == 0) || !last_m1_q;

    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;
    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            last_m1_q <= 1'b0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m1_req && (!m0_req || m1_wins)) begin
                        state_q <= m1_wr_req ? StWrM1 : StRdM1;
                    end else if (m0_req) begin
                        state_q <= StRdM0;
                    end
                end
                StRdM0, StRdM1: begin
                    if (ar_hs) ar_done_q <= 1'b1;
                    if (r_hs) begin
                        state_q   <= StIdle;
                        last_m1_q <= (state_q == StRdM1);
                        ar_done_q <= 1'b0;
                    end
                end
                StWrM1: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_q <= StWresp;
                end
                StWresp: begin
                    if (b_hs) begin
                        state_q   <= StIdle;
                        last_m1_q <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        // Payloads pass through unconditionally; only the handshakes are gated
        s_araddr   = (state_q == StRdM1) ? m1_araddr : m0_araddr;
        s_awaddr   = m1_awaddr;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_bresp   = s_bresp;
        unique case (state_q)
            StRdM0: begin
                s_arvalid  = m0_arvalid && !ar_done_q;
                m0_arready = s_arready && !ar_done_q;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            StRdM1: begin
                s_arvalid  = m1_arvalid && !ar_done_q;
                m1_arready = s_arready && !ar_done_q;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            StWrM1: begin
                s_awvalid  = m1_awvalid && !aw_done_q;
                m1_awready = s_awready && !aw_done_q;
                s_wvalid   = m1_wvalid && !w_done_q;
                m1_wready  = s_wready && !w_done_q;
            end
            StWresp: begin
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: round-robin instance plus a fixed-priority instance,
// each behind a small reactive AXI4-Lite slave model.
module tb_axi_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Master-side stimulus (shared by both instances)
    logic        m0_arvalid = 0, m0_rready = 1;
    logic [31:0] m0_araddr = 0;
    logic        m1_arvalid = 0, m1_rready = 1, m1_awvalid = 0, m1_wvalid = 0, m1_bready = 1;
    logic [31:0] m1_araddr = 0, m1_awaddr = 0, m1_wdata = 0;
    logic [3:0]  m1_wstrb = 0;

    // Slave knobs
    logic        sl_arready = 1, sl_awready = 1, sl_wready = 1;
    logic [31:0] sl_rdata = 0;
    logic [1:0]  sl_rresp = 0;
    logic [3:0]  sl_rdelay = 0;

    // Round-robin DUT wiring
    logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        s_arvalid, s_rvalid, s_rready, s_awvalid, s_wvalid, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;

    // Fixed-priority DUT wiring
    logic        f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid, f_m1_awready, f_m1_wready;
    logic        f_m1_bvalid;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic [1:0]  f_m0_rresp, f_m1_rresp, f_m1_bresp;
    logic        f_s_arvalid, f_s_rvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready;
    logic [31:0] f_s_araddr, f_s_awaddr, f_s_wdata;
    logic [3:0]  f_s_wstrb;

    axi_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(sl_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(sl_rdata), .s_rresp(sl_rresp),
        .s_awvalid(s_awvalid), .s_awready(sl_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(sl_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(2'b00)
    );

    axi_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROUND_ROBIN(0)) fp (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(f_m0_rdata),
        .m0_rresp(f_m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(f_m1_rdata),
        .m1_rresp(f_m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready), .m1_bresp(f_m1_bresp),
        .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_araddr(f_s_araddr),
        .s_rvalid(f_s_rvalid), .s_rready(f_s_rready), .s_rdata(sl_rdata), .s_rresp(2'b00),
        .s_awvalid(f_s_awvalid), .s_awready(1'b0), .s_awaddr(f_s_awaddr),
        .s_wvalid(f_s_wvalid), .s_wready(1'b0), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
        .s_bvalid(1'b0), .s_bready(f_s_bready), .s_bresp(2'b00)
    );

    // Slave model for the round-robin DUT: read latency sl_rdelay, B one cycle after AW and W
    logic       rpend, aw_got, w_got;
    logic [3:0] rwait;
    assign s_rvalid = rpend && (rwait == 4'd0);
    always @(posedge clk) begin
        if (!rst) begin
            rpend <= 0; rwait <= 0; aw_got <= 0; w_got <= 0; s_bvalid <= 0;
        end else begin
            if (s_rvalid && s_rready) rpend <= 0;
            if (s_arvalid && sl_arready) begin
                rpend <= 1;
                rwait <= sl_rdelay;
            end else if (rpend && rwait != 4'd0) begin
                rwait <= rwait - 4'd1;
            end
            if (s_awvalid && sl_awready) aw_got <= 1;
            if (s_wvalid && sl_wready) w_got <= 1;
            if (aw_got && w_got) begin
                s_bvalid <= 1; aw_got <= 0; w_got <= 0;
            end
            if (s_bvalid && s_bready) s_bvalid <= 0;
        end
    end

    // Zero-wait read slave for the fixed-priority DUT
    logic f_rpend;
    assign f_s_rvalid = f_rpend;
    always @(posedge clk) begin
        if (!rst) f_rpend <= 0;
        else if (f_s_arvalid) f_rpend <= 1;
        else if (f_s_rvalid && f_s_rready) f_rpend <= 0;
    end

    logic [11:0] ovec, f_ovec;
    assign ovec = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                   m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    assign f_ovec = {f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid, f_m1_awready,
                     f_m1_wready, f_m1_bvalid, f_s_arvalid, f_s_rready, f_s_awvalid, f_s_wvalid,
                     f_s_bready};

    int checks = 0;
    int errors = 0;

    // Masters must hold valid until their handshake on the round-robin DUT
    logic [3:0] hold = 4'b0;
    always @(negedge clk) begin
        if (rst && |(hold & ~{m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid})) begin
            errors++;
            $error("FAIL valid_hold observed=%b expected=%b", {m0_arvalid, m1_arvalid,
                   m1_awvalid, m1_wvalid}, hold);
        end
        hold <= rst ? ({m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid} &
                       ~{m0_arready, m1_arready, m1_awready, m1_wready}) : 4'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [11:0] e);
        @(negedge clk);
        chk(tag, 32'(ovec), 32'(e));
    endtask

    task automatic do_reset();
        rst = 0;
        m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        sl_wready = 1; sl_rdelay = 0; sl_rresp = 0;
        nxt();
        rst = 1;
    endtask

    localparam logic [31:0] A0 = 32'h8000_0100;
    localparam logic [31:0] A1 = 32'h8000_0200;

    initial begin
        logic [3:0]  g_rr, g_fp;
        logic [11:0] e;
        logic        g;
        int          k, p;

        // Reset with every request asserted
        m0_arvalid = 1; m1_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        m0_araddr = A0; m1_araddr = A1;
        nxt();
        cyc("rst_c1", 12'h000); nxt();
        cyc("rst_c2", 12'h000); nxt();
        rst = 1;
        cyc("rel_idle", 12'h000); nxt();
        cyc("first_grant_m1_wr", 12'h0C6); nxt();
        do_reset();

        // Solo IFU read, zero-wait slave
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; sl_rdata = 32'h0000_0413;
        cyc("ifu_t0", 12'h000); nxt();
        cyc("ifu_t1_ar", 12'h818); chk("ifu_araddr", s_araddr, 32'h8000_0000); nxt();
        m0_arvalid = 0;
        cyc("ifu_t2_r", 12'h408); chk("ifu_rdata", m0_rdata, 32'h0000_0413);
        chk("ifu_rresp", 32'(m0_rresp), 32'd0); nxt();
        cyc("ifu_t3_idle", 12'h000); nxt();
        do_reset();

        // Continuous tie; M1 stops after its third read
        m0_arvalid = 1; m0_araddr = A0; m1_arvalid = 1; m1_araddr = A1;
        sl_rdata = 32'h1234_5678;
        g_rr = 4'b0101;
        g_fp = 4'b0111;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) m1_arvalid = 0;
            if (c == 11) m0_arvalid = 0;
            k = c / 3;
            p = c % 3;
            g = g_rr[k];
            e = (p == 0) ? 12'h000 : (p == 1) ? (g ? 12'h218 : 12'h818) : (g ? 12'h108 : 12'h408);
            cyc($sformatf("rr_c%0d", c), e);
            if (p == 1) chk($sformatf("rr_addr_c%0d", c), s_araddr, g ? A1 : A0);
            if (p == 2) chk($sformatf("rr_data_c%0d", c), g ? m1_rdata : m0_rdata, 32'h1234_5678);
            g = g_fp[k];
            e = (p == 0) ? 12'h000 : (p == 1) ? (g ? 12'h218 : 12'h818) : (g ? 12'h108 : 12'h408);
            chk($sformatf("fp_c%0d", c), 32'(f_ovec), 32'(e));
            if (p == 1) chk($sformatf("fp_addr_c%0d", c), f_s_araddr, g ? A1 : A0);
            nxt();
        end
        do_reset();

        // LSU write: AW accepted at once, W ready held off until cycle 4
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h8000_1000;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011; sl_wready = 0;
        cyc("wr_t0", 12'h000); nxt();
        cyc("wr_t1_aw", 12'h086); chk("wr_awaddr", s_awaddr, 32'h8000_1000); nxt();
        m1_awvalid = 0;
        cyc("wr_t2_wwait", 12'h002); nxt();
        cyc("wr_t3_wwait", 12'h002); nxt();
        sl_wready = 1;
        cyc("wr_t4_w", 12'h042); chk("wr_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(s_wstrb), 32'h3); nxt();
        m1_wvalid = 0;
        cyc("wr_t5_wresp", 12'h001); nxt();
        cyc("wr_t6_b", 12'h021); chk("wr_bresp", 32'(m1_bresp), 32'd0); nxt();
        cyc("wr_t7_idle", 12'h000); nxt();
        do_reset();

        // M1 read+write with M0 read pending: write, M0 read, M1 read
        m0_arvalid = 1; m0_araddr = A0; m1_arvalid = 1; m1_araddr = A1;
        m1_awvalid = 1; m1_wvalid = 1;
        cyc("mix_t0", 12'h000); nxt();
        cyc("mix_t1_wr", 12'h0C6); nxt();
        m1_awvalid = 0; m1_wvalid = 0;
        cyc("mix_t2_wresp", 12'h001); nxt();
        cyc("mix_t3_b", 12'h021); nxt();
        cyc("mix_t4_idle", 12'h000); nxt();
        cyc("mix_t5_m0ar", 12'h818); chk("mix_m0_addr", s_araddr, A0); nxt();
        m0_arvalid = 0;
        cyc("mix_t6_m0r", 12'h408); nxt();
        cyc("mix_t7_idle", 12'h000); nxt();
        cyc("mix_t8_m1ar", 12'h218); chk("mix_m1_addr", s_araddr, A1); nxt();
        m1_arvalid = 0;
        cyc("mix_t9_m1r", 12'h108); nxt();
        cyc("mix_t10_idle", 12'h000); nxt();
        do_reset();

        // Stalled slave returning SLVERR
        sl_rdelay = 4'd5; sl_rresp = 2'b10; sl_rdata = 32'hCAFE_0001;
        m0_arvalid = 1; m0_araddr = A0;
        cyc("stall_t0", 12'h000); nxt();
        cyc("stall_t1_ar", 12'h818); nxt();
        m0_arvalid = 0;
        for (int c = 2; c < 7; c++) begin
            cyc($sformatf("stall_wait_t%0d", c), 12'h008);
            nxt();
        end
        cyc("stall_t7_r", 12'h408); chk("stall_rresp", 32'(m0_rresp), 32'h2);
        chk("stall_rdata", m0_rdata, 32'hCAFE_0001); nxt();
        cyc("stall_t8_idle", 12'h000); nxt();
        do_reset();

        // Same stall, aborted by reset mid-wait
        sl_rdelay = 4'd5; sl_rresp = 2'b10;
        m0_arvalid = 1; m0_araddr = A0;
        cyc("abort_t0", 12'h000); nxt();
        cyc("abort_t1_ar", 12'h818); nxt();
        m0_arvalid = 0;
        cyc("abort_t2_wait", 12'h008); nxt();
        rst = 0;
        cyc("abort_t3_rst", 12'h008); nxt();
        rst = 1;
        for (int c = 4; c < 10; c++) begin
            cyc($sformatf("abort_idle_t%0d", c), 12'h000);
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
